// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial transmit path.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PEND   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } tx_state_e;

  // Whole frame in bit periods, excluding the PEND alignment wait.
  function automatic int frame_len(input int data_w, input int parity_en, input int stop_bits);
    return 1 + data_w + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/serial_tx_framer.sv
// UART-style transmit framer: start bit, DATA_W data bits LSB first, optional
// parity, one or two stop bits, each held for one bit_tick period.
module serial_tx_framer
  import serial_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_tick,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy
);

  localparam int                IDX_W     = $clog2(DATA_W);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              stop_q, stop_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  function automatic logic calc_parity(input logic [DATA_W-1:0] d);
    return (^d) ^ 1'(PARITY_ODD);
  endfunction

  // Next-state, shift register and line-value logic.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    par_d   = par_q;
    tx_d    = tx_q;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_valid && ready_q) begin
          shift_d = tx_data;
          par_d   = calc_parity(tx_data);
          state_d = PEND;
        end else begin
          state_d = IDLE;
        end
      end
      PEND: begin
        if (bit_tick) begin
          state_d = START;
          tx_d    = 1'b0;
        end else begin
          tx_d    = 1'b1;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          idx_d   = '0;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        // The word shifts right each period so the next bit is always at [1].
        if (bit_tick) begin
          if (idx_q < IDX_LAST) begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1'b1;
            tx_d    = shift_q[1];
          end else if (PARITY_EN != 0) begin
            state_d = PARITY;
            tx_d    = par_q;
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
            stop_d  = 1'b0;
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (bit_tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
          stop_d  = 1'b0;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_tick) begin
          if (stop_q == STOP_LAST) begin
            state_d = IDLE;
          end else begin
            stop_d  = 1'b1;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign tx_ready = ready_q;
  assign tx       = tx_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_serial_tx_framer.sv
// Bench for serial_tx_framer: three parameter variants driven in parallel and
// checked every cycle against a frame-list reference model.
module tb_serial_tx_framer;
  import serial_pkg::*;

  localparam int DW = 8;
  localparam int NI = 3;
  localparam int PE [NI] = '{1, 1, 0};
  localparam int PO [NI] = '{0, 1, 0};
  localparam int SB [NI] = '{1, 1, 2};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic [1:0]    tick_cnt = 2'd0;
  logic          bit_tick;
  logic [NI-1:0] tx_o, rdy_o, bsy_o;

  int checks = 0;
  int passes = 0;

  logic [NI-1:0] e_tx, e_rdy, e_bsy;
  bit   m_busy [NI];
  bit   m_pend [NI];
  int   m_pos [NI];
  int   m_len [NI];
  int   m_acc [NI];
  logic m_frame [NI][16];

  always #5 clk = ~clk;

  // Bit-rate counter with NUM=3: one tick every 4 cycles.
  always @(posedge clk) tick_cnt <= tick_cnt + 2'd1;
  assign bit_tick = (tick_cnt == 2'd3);

  for (genvar g = 0; g < NI; g++) begin : g_dut
    serial_tx_framer #(
      .DATA_W(DW), .PARITY_EN(PE[g]), .PARITY_ODD(PO[g]), .STOP_BITS(SB[g])
    ) dut (
      .clk(clk), .rst_n(rst_n), .bit_tick(bit_tick), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(rdy_o[g]), .tx(tx_o[g]), .busy(bsy_o[g])
    );
  end

  // Advance the model across the coming posedge using the inputs now driven.
  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        m_busy[i] = 1'b0; m_pend[i] = 1'b0;
        e_tx[i] = 1'b1; e_rdy[i] = 1'b0; e_bsy[i] = 1'b0;
      end else if (!m_busy[i]) begin
        if (tx_valid && e_rdy[i]) begin
          m_len[i] = frame_len(DW, PE[i], SB[i]);
          for (int k = 0; k < 16; k++) m_frame[i][k] = 1'b1;
          m_frame[i][0] = 1'b0;
          for (int b = 0; b < DW; b++) m_frame[i][1+b] = tx_data[b];
          if (PE[i] != 0) m_frame[i][1+DW] = (^tx_data) ^ (PO[i] != 0);
          m_busy[i] = 1'b1; m_pend[i] = 1'b1;
          e_rdy[i] = 1'b0; e_bsy[i] = 1'b1; e_tx[i] = 1'b1;
          m_acc[i]++;
        end else begin
          e_rdy[i] = 1'b1;
        end
      end else if (bit_tick) begin
        if (m_pend[i]) begin
          m_pend[i] = 1'b0; m_pos[i] = 0;
        end else begin
          m_pos[i]++;
        end
        if (m_pos[i] == m_len[i]) begin
          m_busy[i] = 1'b0; e_tx[i] = 1'b1; e_rdy[i] = 1'b1; e_bsy[i] = 1'b0;
        end else begin
          e_tx[i] = m_frame[i][m_pos[i]];
        end
      end
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        checks++;
        if ({tx_o[i], rdy_o[i], bsy_o[i]} !== {e_tx[i], e_rdy[i], e_bsy[i]})
          $display("FAIL reset dut%0d t=%0t tx/rdy/busy got %b%b%b want %b%b%b", i, $time,
                   tx_o[i], rdy_o[i], bsy_o[i], e_tx[i], e_rdy[i], e_bsy[i]);
        else passes++;
      end
      if (c == 1) begin
        checks++;
        if ({tx_o, rdy_o, bsy_o} !== {3'b111, 3'b000, 3'b000})
          $display("FAIL reset_state got tx=%b rdy=%b busy=%b want 111/000/000", tx_o, rdy_o, bsy_o);
        else passes++;
      end
      if (c == 4) begin
        checks++;
        if (rdy_o !== 3'b111)
          $display("FAIL ready_after_release got %b want 111", rdy_o);
        else passes++;
      end
      rst_n = (c >= 3);
      tx_valid = 1'b0;
      model_step();
    end
  endtask

  task automatic test_frames();
    logic [DW-1:0] words [3];
    int   expv [11];
    logic trace [$];
    bit   started;
    bit   ok;
    words = '{8'hA5, 8'h00, 8'hFF};
    for (int w = 0; w < 3; w++) begin
      case (w)
        0:       expv = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
        1:       expv = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        default: expv = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
      endcase
      trace.delete();
      started = 1'b0;
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
          checks++;
          if ({tx_o[i], rdy_o[i], bsy_o[i]} !== {e_tx[i], e_rdy[i], e_bsy[i]})
            $display("FAIL frames w%0d dut%0d t=%0t tx/rdy/busy got %b%b%b want %b%b%b", w, i, $time,
                     tx_o[i], rdy_o[i], bsy_o[i], e_tx[i], e_rdy[i], e_bsy[i]);
          else passes++;
        end
        if (!started && tx_o[w] === 1'b0) started = 1'b1;
        if (started) trace.push_back(tx_o[w]);
        tx_valid = (c == 0);
        tx_data  = words[w];
        model_step();
      end
      // The target variant for each word: 0xA5 even, 0x00 odd, 0xFF no-parity/2-stop.
      for (int k = 0; k < 11; k++) begin
        ok = (trace.size() >= 4*k + 4);
        if (ok) for (int j = 0; j < 4; j++) if (trace[4*k+j] !== 1'(expv[k])) ok = 1'b0;
        checks++;
        if (!ok)
          $display("FAIL period w%0d dut%0d bit%0d got %b want %0d held 4 cycles", w, w, k,
                   (trace.size() > 4*k+1) ? trace[4*k+1] : 1'bx, expv[k]);
        else passes++;
      end
    end
  endtask

  task automatic test_disturb();
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        checks++;
        if ({tx_o[i], rdy_o[i], bsy_o[i]} !== {e_tx[i], e_rdy[i], e_bsy[i]})
          $display("FAIL disturb dut%0d t=%0t tx/rdy/busy got %b%b%b want %b%b%b", i, $time,
                   tx_o[i], rdy_o[i], bsy_o[i], e_tx[i], e_rdy[i], e_bsy[i]);
        else passes++;
      end
      if (c == 0) begin
        tx_valid = 1'b1;
        tx_data  = DW'($urandom);
      end else if (m_busy[0] && !m_pend[0] && m_pos[0] >= 2 && m_pos[0] <= 6) begin
        tx_valid = 1'($urandom_range(0, 1));
        tx_data  = DW'($urandom);
      end else begin
        tx_valid = 1'b0;
      end
      model_step();
    end
  endtask

  task automatic test_back_to_back();
    int base = m_acc[0];
    int gap = 0;
    bit done = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        checks++;
        if ({tx_o[i], rdy_o[i], bsy_o[i]} !== {e_tx[i], e_rdy[i], e_bsy[i]})
          $display("FAIL b2b dut%0d t=%0t tx/rdy/busy got %b%b%b want %b%b%b", i, $time,
                   tx_o[i], rdy_o[i], bsy_o[i], e_tx[i], e_rdy[i], e_bsy[i]);
        else passes++;
      end
      if (m_acc[0] - base == 1 && rdy_o[0] === 1'b1) gap++;
      if (m_acc[0] - base >= 2) begin
        tx_valid = 1'b0;
      end else begin
        tx_valid = 1'b1;
        tx_data  = (m_acc[0] == base) ? 8'h12 : 8'h34;
      end
      model_step();
      if (m_acc[0] - base >= 2 && !m_busy[0]) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) $display("FAIL b2b_timeout got %0d frames want 2 within 200 cycles", m_acc[0] - base);
    else passes++;
    checks++;
    if (gap != 1) $display("FAIL b2b_ready_gap got %0d cycles want 1", gap);
    else passes++;
  endtask

  task automatic test_reset_mid();
    bit hit = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        checks++;
        if ({tx_o[i], rdy_o[i], bsy_o[i]} !== {e_tx[i], e_rdy[i], e_bsy[i]})
          $display("FAIL rstmid_a dut%0d t=%0t tx/rdy/busy got %b%b%b want %b%b%b", i, $time,
                   tx_o[i], rdy_o[i], bsy_o[i], e_tx[i], e_rdy[i], e_bsy[i]);
        else passes++;
      end
      tx_valid = (c == 0);
      if (c == 0) tx_data = DW'($urandom);
      if (m_busy[0] && !m_pend[0] && m_pos[0] == 4) begin
        rst_n = 1'b0;
        hit = 1'b1;
      end
      model_step();
      if (hit) break;
    end
    checks++;
    if (!hit) $display("FAIL rstmid_timeout got no data bit 3 within 60 cycles want one");
    else passes++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (tx_o[0] !== 1'b1 || rdy_o[0] !== 1'b0)
          $display("FAIL rstmid_line got tx=%b rdy=%b want tx=1 rdy=0", tx_o[0], rdy_o[0]);
        else passes++;
      end
      for (int i = 0; i < NI; i++) begin
        checks++;
        if ({tx_o[i], rdy_o[i], bsy_o[i]} !== {e_tx[i], e_rdy[i], e_bsy[i]})
          $display("FAIL rstmid_b dut%0d t=%0t tx/rdy/busy got %b%b%b want %b%b%b", i, $time,
                   tx_o[i], rdy_o[i], bsy_o[i], e_tx[i], e_rdy[i], e_bsy[i]);
        else passes++;
      end
      tx_valid = 1'b0;
      rst_n = (c == 2);
      model_step();
    end
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (rdy_o !== 3'b111 || tx_o !== 3'b111)
          $display("FAIL rstmid_release got rdy=%b tx=%b want 111/111", rdy_o, tx_o);
        else passes++;
      end
      for (int i = 0; i < NI; i++) begin
        checks++;
        if ({tx_o[i], rdy_o[i], bsy_o[i]} !== {e_tx[i], e_rdy[i], e_bsy[i]})
          $display("FAIL rstmid_c dut%0d t=%0t tx/rdy/busy got %b%b%b want %b%b%b", i, $time,
                   tx_o[i], rdy_o[i], bsy_o[i], e_tx[i], e_rdy[i], e_bsy[i]);
        else passes++;
      end
      tx_valid = (c == 3);
      if (c == 3) tx_data = DW'($urandom);
      model_step();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        checks++;
        if ({tx_o[i], rdy_o[i], bsy_o[i]} !== {e_tx[i], e_rdy[i], e_bsy[i]})
          $display("FAIL random dut%0d t=%0t tx/rdy/busy got %b%b%b want %b%b%b", i, $time,
                   tx_o[i], rdy_o[i], bsy_o[i], e_tx[i], e_rdy[i], e_bsy[i]);
        else passes++;
      end
      tx_valid = (c < 740) && ($urandom_range(0, 2) == 0);
      tx_data  = DW'($urandom);
      model_step();
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    for (int i = 0; i < NI; i++) begin
      m_pos[i] = 0; m_len[i] = 0; m_acc[i] = 0;
    end
    model_step();
    test_reset();
    test_frames();
    test_disturb();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
